// File: rtl/biterr_pattern_gen.sv
// Transmit-side training pattern generator (zeros / fixed word / PRBS-7 / alternating)
// with command and periodic single-bit error injection and a saturating injection count.
module biterr_pattern_gen #(
    parameter int unsigned       WIDTH      = 8,
    parameter logic [WIDTH-1:0]  TRAIN_WORD = 8'hA6
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             enable_i,
    input  logic [1:0]       mode_i,
    input  logic             inject_i,
    input  logic [23:0]      interval_i,
    input  logic             interval_load_i,
    input  logic             count_clear_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic [24:0]      inject_count_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SEED = 2'b01,
        ST_RUN  = 2'b10
    } state_e;

    localparam logic [1:0]  MODE_ZERO  = 2'b00;
    localparam logic [1:0]  MODE_TRAIN = 2'b01;
    localparam logic [1:0]  MODE_PRBS  = 2'b10;
    localparam logic [6:0]  LFSR_SEED  = 7'h7F;
    localparam logic [24:0] COUNT_MAX  = 25'h1FF_FFFF;

    state_e            state_q, state_d;
    logic [1:0]        mode_prev_q;
    logic [6:0]        lfsr_q, lfsr_d;
    logic              phase_q, phase_d;
    logic [23:0]       timer_q, timer_d;
    logic [23:0]       interval_q, interval_d;
    logic [24:0]       inject_count_q, inject_count_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic              valid_q, valid_d;

    logic [WIDTH-1:0]  prbs_word;
    logic [6:0]        prbs_next;
    logic [WIDTH-1:0]  pattern;
    logic              run_word;
    logic              periodic_hit;
    logic              flip;

    // ---------------- FSM: state register ----------------
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    // NOTE: a default assignment before the case keeps combinational blocks latch-free.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (enable_i) state_d = ST_SEED;
            ST_SEED: state_d = enable_i ? ST_RUN : ST_IDLE;
            ST_RUN: begin
                if (!enable_i)                 state_d = ST_IDLE;
                else if (mode_i != mode_prev_q) state_d = ST_SEED;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign run_word = (state_d == ST_RUN);

    // WIDTH successive PRBS-7 bits, first generated bit lands in the MSB.
    // NOTE: blocking (=) here is intentional: the loop chains LFSR steps within one evaluation.
    always_comb begin : prbs_gen
        logic [6:0] s;
        logic       nb;
        s         = lfsr_q;
        nb        = 1'b0;
        prbs_word = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            nb           = s[6] ^ s[5];
            s            = {s[5:0], nb};
            prbs_word[i] = nb;
        end
        prbs_next = s;
    end

    always_comb begin
        case (mode_i)
            MODE_ZERO:  pattern = '0;
            MODE_TRAIN: pattern = TRAIN_WORD;
            MODE_PRBS:  pattern = prbs_word;
            default:    pattern = phase_q ? ~TRAIN_WORD : TRAIN_WORD;
        endcase
    end

    // Timer counts words remaining until the next periodic flip; 1 means "this word".
    assign periodic_hit = (interval_q != '0) && (timer_q == 24'd1);
    assign flip         = run_word && (inject_i || periodic_hit);

    // ---------------- Datapath next-state ----------------
    always_comb begin
        interval_d = interval_load_i ? interval_i : interval_q;
        lfsr_d     = lfsr_q;
        phase_d    = phase_q;
        timer_d    = timer_q;

        if (state_d == ST_SEED) begin
            lfsr_d  = LFSR_SEED;
            phase_d = 1'b0;
            timer_d = interval_d;
        end else if (run_word) begin
            lfsr_d  = prbs_next;
            phase_d = ~phase_q;
            if (interval_load_i)    timer_d = interval_i;
            else if (periodic_hit)  timer_d = interval_q;
            else if (timer_q != '0) timer_d = timer_q - 24'd1;
        end

        if (count_clear_i)                          inject_count_d = '0;
        else if (flip && inject_count_q != COUNT_MAX) inject_count_d = inject_count_q + 25'd1;
        else                                        inject_count_d = inject_count_q;
    end

    // ---------------- FSM: output logic (registered outputs) ----------------
    always_comb begin
        data_d  = '0;
        valid_d = 1'b0;
        if (run_word) begin
            data_d  = pattern ^ WIDTH'(flip);
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mode_prev_q    <= MODE_ZERO;
            lfsr_q         <= LFSR_SEED;
            phase_q        <= 1'b0;
            timer_q        <= '0;
            interval_q     <= '0;
            inject_count_q <= '0;
            data_q         <= '0;
            valid_q        <= 1'b0;
        end else begin
            mode_prev_q    <= mode_i;
            lfsr_q         <= lfsr_d;
            phase_q        <= phase_d;
            timer_q        <= timer_d;
            interval_q     <= interval_d;
            inject_count_q <= inject_count_d;
            data_q         <= data_d;
            valid_q        <= valid_d;
        end
    end

    assign data_o         = data_q;
    assign valid_o        = valid_q;
    assign inject_count_o = inject_count_q;

endmodule

// File: tb/tb_biterr_pattern_gen.sv
// Directed bench for biterr_pattern_gen: patterns, mode-change gap, periodic and
// command injection, clear priority, count saturation and asynchronous reset.
module tb_biterr_pattern_gen;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        enable_i;
    logic [1:0]  mode_i;
    logic        inject_i;
    logic [23:0] interval_i;
    logic        interval_load_i;
    logic        count_clear_i;
    logic [7:0]  data_o;
    logic        valid_o;
    logic [24:0] inject_count_o;

    int errors = 0;
    int checks = 0;
    logic [7:0] words [0:127];

    biterr_pattern_gen #(.WIDTH(8), .TRAIN_WORD(8'hA6)) dut (
        .clk_i           (clk_i),
        .rst_n_i         (rst_n_i),
        .enable_i        (enable_i),
        .mode_i          (mode_i),
        .inject_i        (inject_i),
        .interval_i      (interval_i),
        .interval_load_i (interval_load_i),
        .count_clear_i   (count_clear_i),
        .data_o          (data_o),
        .valid_o         (valid_o),
        .inject_count_o  (inject_count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One rising edge passes; returns on the following falling edge.
    task automatic tick();
        @(negedge clk_i);
    endtask

    initial begin
        rst_n_i         = 1'b0;
        enable_i        = 1'b0;
        mode_i          = 2'b00;
        inject_i        = 1'b0;
        interval_i      = '0;
        interval_load_i = 1'b0;
        count_clear_i   = 1'b0;

        // Reset state
        #12;
        check("rst_data",  {24'd0, data_o}, 32'h0);
        check("rst_valid", {31'd0, valid_o}, 32'h0);
        check("rst_count", {7'd0, inject_count_o}, 32'h0);
        tick();
        rst_n_i = 1'b1;

        // PRBS-7: valid two edges after enable, 02, 0C, 28 ..., period 127 words
        mode_i   = 2'b10;
        enable_i = 1'b1;
        tick();
        check("seed_valid", {31'd0, valid_o}, 32'h0);
        tick();
        check("run_valid", {31'd0, valid_o}, 32'h1);
        words[0] = data_o;
        for (int i = 1; i < 128; i++) begin
            tick();
            words[i] = data_o;
        end
        check("prbs_w0",   {24'd0, words[0]},   32'h02);
        check("prbs_w1",   {24'd0, words[1]},   32'h0C);
        check("prbs_w2",   {24'd0, words[2]},   32'h28);
        check("prbs_w127", {24'd0, words[127]}, 32'h02);
        check("prbs_count", {7'd0, inject_count_o}, 32'h0);

        // Mode 10 -> 01: one gap then constant A6
        mode_i = 2'b01;
        tick();
        check("gap_10_01", {31'd0, valid_o}, 32'h0);
        tick();
        check("train_w0", {23'd0, valid_o, data_o}, 32'h1A6);
        tick();
        check("train_w1", {24'd0, data_o}, 32'hA6);

        // Mode 01 -> 11: one gap then A6,59,A6
        mode_i = 2'b11;
        tick();
        check("gap_01_11", {31'd0, valid_o}, 32'h0);
        tick();
        check("alt_w0", {23'd0, valid_o, data_o}, 32'h1A6);
        tick();
        check("alt_w1", {24'd0, data_o}, 32'h59);
        tick();
        check("alt_w2", {24'd0, data_o}, 32'hA6);

        // Disable -> IDLE outputs zero
        enable_i = 1'b0;
        tick();
        check("idle_out", {23'd0, valid_o, data_o}, 32'h0);

        // Interval 5 loaded in IDLE, mode 01: flips at 4, 9, 14, 19
        mode_i          = 2'b01;
        interval_i      = 24'd5;
        interval_load_i = 1'b1;
        tick();
        interval_load_i = 1'b0;
        enable_i        = 1'b1;
        tick();
        for (int i = 0; i < 20; i++) begin
            tick();
            words[i] = data_o;
        end
        check("per_w0",  {24'd0, words[0]},  32'hA6);
        check("per_w4",  {24'd0, words[4]},  32'hA7);
        check("per_w5",  {24'd0, words[5]},  32'hA6);
        check("per_w9",  {24'd0, words[9]},  32'hA7);
        check("per_w14", {24'd0, words[14]}, 32'hA7);
        check("per_w19", {24'd0, words[19]}, 32'hA7);
        check("per_count", {7'd0, inject_count_o}, 32'd4);

        // inject_i coinciding with periodic flip at word 24: one flip, one count
        repeat (4) tick();
        inject_i = 1'b1;
        tick();
        inject_i = 1'b0;
        check("coinc_data",  {24'd0, data_o}, 32'hA7);
        check("coinc_count", {7'd0, inject_count_o}, 32'd5);

        // Lone inject_i at word 25
        inject_i = 1'b1;
        tick();
        inject_i = 1'b0;
        check("cmd_data",  {24'd0, data_o}, 32'hA7);
        check("cmd_count", {7'd0, inject_count_o}, 32'd6);

        // Clear coinciding with periodic flip at word 29: clear wins
        repeat (3) tick();
        count_clear_i = 1'b1;
        tick();
        count_clear_i = 1'b0;
        check("clr_data",  {24'd0, data_o}, 32'hA7);
        check("clr_count", {7'd0, inject_count_o}, 32'd0);

        // inject_i in IDLE is discarded
        enable_i = 1'b0;
        tick();
        inject_i = 1'b1;
        tick();
        inject_i = 1'b0;
        check("idle_inj_out",   {23'd0, valid_o, data_o}, 32'h0);
        check("idle_inj_count", {7'd0, inject_count_o}, 32'd0);

        // Interval 1: every word flipped; count saturates
        interval_i      = 24'd1;
        interval_load_i = 1'b1;
        enable_i        = 1'b1;
        tick();
        interval_load_i = 1'b0;
        tick();
        check("int1_data",  {24'd0, data_o}, 32'hA7);
        check("int1_count", {7'd0, inject_count_o}, 32'd1);
        force dut.inject_count_q = 25'h1FF_FFFC;
        #1;
        release dut.inject_count_q;
        repeat (3) tick();
        check("sat_reach", {7'd0, inject_count_o}, 32'h1FF_FFFF);
        repeat (2) tick();
        check("sat_hold",  {7'd0, inject_count_o}, 32'h1FF_FFFF);
        check("sat_data",  {24'd0, data_o}, 32'hA7);

        // Asynchronous reset mid-RUN, between clock edges
        #2;
        rst_n_i = 1'b0;
        #1;
        check("arst_out",   {23'd0, valid_o, data_o}, 32'h0);
        check("arst_count", {7'd0, inject_count_o}, 32'h0);
        tick();
        mode_i  = 2'b10;
        rst_n_i = 1'b1;
        tick();
        check("rerun_seed", {31'd0, valid_o}, 32'h0);
        tick();
        check("rerun_w0", {23'd0, valid_o, data_o}, 32'h102);
        tick();
        check("rerun_w1", {24'd0, data_o}, 32'h0C);
        check("rerun_count", {7'd0, inject_count_o}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
